morse_keyer: RTL

Character-to-Morse timing engine directly upstream of the tone generator. Accepts one ASCII character per valid/ready handshake, looks up its Morse pattern and drives mutually exclusive `dit`/`dah` levels with standard unit timing (dit 1, dah 3, element gap 1, character gap 3, word gap 7 units). Its `dit`/`dah` outputs connect straight to the tone generator's `dit`/`dah` inputs; the PS/2 decode path feeds `char_data`.

---
 rtl/morse_keyer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/morse_keyer.sv
// morse_keyer -- ASCII character to Morse dit/dah timing engine.
//
// Accepts one character per char_valid/char_ready handshake, looks up its
// Morse pattern and drives mutually exclusive dit/dah levels with standard
// unit timing: dit 1, dah 3, element gap 1, character gap 3 units.
// A space adds a further 4-unit gap (7 units after a character's 3-unit gap).
//
// Parameters:
//   UNIT_CYCLES  clock cycles per Morse unit (1 .. 2^CNT_W-1)
//   CNT_W        width of the cycle counter
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   char_data     in   [7:0] ASCII character, sampled only at transfer
//   char_valid    in   char_data valid
//   char_ready    out  keyer idle, accepts a character
//   dit           out  high for the duration of a dit element
//   dah           out  high for the duration of a dah element
//   busy          out  high whenever the FSM is not idle
//   char_invalid  out  one-cycle pulse when an unsupported character is taken
//
// Build option: define MORSE_PUNCT_EN to add . , ? / = to the table
// (patterns up to 6 elements). Without it those characters are invalid.
module morse_keyer #(
    parameter int UNIT_CYCLES = 3000000,
    parameter int CNT_W       = 22
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       dit,
    output logic       dah,
    output logic       busy,
    output logic       char_invalid
);

`ifdef MORSE_PUNCT_EN
    localparam int MAXL = 6;
`else
    localparam int MAXL = 5;
`endif

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MARK     = 3'd1;
    localparam logic [2:0] S_ELEM_GAP = 3'd2;
    localparam logic [2:0] S_CHAR_GAP = 3'd3;
    localparam logic [2:0] S_WORD_GAP = 3'd4;

    localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       unit_q, unit_d;
    logic [MAXL-1:0]  pat_q, pat_d;     // remaining elements, MSB = current
    logic [2:0]       rem_q, rem_d;     // elements left including current
    logic             ready_q, dit_q, dah_q, busy_q, inval_q;
    logic             inval_d;

    // ---------------- character lookup ----------------
    logic [7:0] up_char;
    logic [8:0] entry;      // {length, elements right-aligned, 1 = dah}
    logic       is_space;
    logic       xfer;

    always_comb begin
        up_char = char_data;
        if (char_data >= 8'h61 && char_data <= 8'h7a)
            up_char = char_data - 8'h20;
        is_space = (char_data == 8'h20);
        case (up_char)
            "A": entry = {3'd2, 6'b01};
            "B": entry = {3'd4, 6'b1000};
            "C": entry = {3'd4, 6'b1010};
            "D": entry = {3'd3, 6'b100};
            "E": entry = {3'd1, 6'b0};
            "F": entry = {3'd4, 6'b0010};
            "G": entry = {3'd3, 6'b110};
            "H": entry = {3'd4, 6'b0000};
            "I": entry = {3'd2, 6'b00};
            "J": entry = {3'd4, 6'b0111};
            "K": entry = {3'd3, 6'b101};
            "L": entry = {3'd4, 6'b0100};
            "M": entry = {3'd2, 6'b11};
            "N": entry = {3'd2, 6'b10};
            "O": entry = {3'd3, 6'b111};
            "P": entry = {3'd4, 6'b0110};
            "Q": entry = {3'd4, 6'b1101};
            "R": entry = {3'd3, 6'b010};
            "S": entry = {3'd3, 6'b000};
            "T": entry = {3'd1, 6'b1};
            "U": entry = {3'd3, 6'b001};
            "V": entry = {3'd4, 6'b0001};
            "W": entry = {3'd3, 6'b011};
            "X": entry = {3'd4, 6'b1001};
            "Y": entry = {3'd4, 6'b1011};
            "Z": entry = {3'd4, 6'b1100};
            "0": entry = {3'd5, 6'b11111};
            "1": entry = {3'd5, 6'b01111};
            "2": entry = {3'd5, 6'b00111};
            "3": entry = {3'd5, 6'b00011};
            "4": entry = {3'd5, 6'b00001};
            "5": entry = {3'd5, 6'b00000};
            "6": entry = {3'd5, 6'b10000};
            "7": entry = {3'd5, 6'b11000};
            "8": entry = {3'd5, 6'b11100};
            "9": entry = {3'd5, 6'b11110};
`ifdef MORSE_PUNCT_EN
            ".": entry = {3'd6, 6'b010101};
            ",": entry = {3'd6, 6'b110011};
            "?": entry = {3'd6, 6'b001100};
            "/": entry = {3'd5, 6'b10010};
            "=": entry = {3'd5, 6'b10001};
`endif
            default: entry = 9'd0;
        endcase
    end

    // ---------------- unit timing ----------------
    logic [2:0] unit_top;   // index of the last unit in the current state
    logic       unit_done;
    logic       state_done;

    always_comb begin
        case (state_q)
            S_MARK:     unit_top = pat_q[MAXL-1] ? 3'd2 : 3'd0;
            S_CHAR_GAP: unit_top = 3'd2;
            S_WORD_GAP: unit_top = 3'd3;
            default:    unit_top = 3'd0;
        endcase
    end

    assign unit_done  = (cnt_q == UNIT_LAST);
    assign state_done = unit_done && (unit_q == unit_top);
    // ready_q is only high in IDLE, so it doubles as the acceptance qualifier
    assign xfer       = char_valid && ready_q;

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        inval_d = 1'b0;
        cnt_d   = unit_done ? '0 : cnt_q + CNT_W'(1);
        unit_d  = unit_done ? unit_q + 3'd1 : unit_q;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    if (entry[8:6] != 3'd0) begin
                        state_d = S_MARK;
                        // left-align the pattern so the MSB is the first element
                        pat_d   = MAXL'(entry[5:0] << (3'(MAXL) - entry[8:6]));
                        rem_d   = entry[8:6];
                    end else if (is_space) begin
                        state_d = S_WORD_GAP;
                    end else begin
                        inval_d = 1'b1;
                    end
                end
            end
            S_MARK: begin
                if (state_done) begin
                    if (rem_q > 3'd1) begin
                        state_d = S_ELEM_GAP;
                        pat_d   = {pat_q[MAXL-2:0], 1'b0};
                        rem_d   = rem_q - 3'd1;
                    end else begin
                        state_d = S_CHAR_GAP;
                    end
                end
            end
            S_ELEM_GAP: if (state_done) state_d = S_MARK;
            S_CHAR_GAP: if (state_done) state_d = S_IDLE;
            S_WORD_GAP: if (state_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        // both counters restart on every state entry; they idle at zero
        if (state_d != state_q || state_q == S_IDLE) begin
            cnt_d  = '0;
            unit_d = 3'd0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            unit_q  <= 3'd0;
            pat_q   <= '0;
            rem_q   <= 3'd0;
            ready_q <= 1'b0;
            dit_q   <= 1'b0;
            dah_q   <= 1'b0;
            busy_q  <= 1'b0;
            inval_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            unit_q  <= unit_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            // outputs are decoded from the next state so they line up with it
            ready_q <= (state_d == S_IDLE);
            busy_q  <= (state_d != S_IDLE);
            dit_q   <= (state_d == S_MARK) && !pat_d[MAXL-1];
            dah_q   <= (state_d == S_MARK) &&  pat_d[MAXL-1];
            inval_q <= inval_d;
        end
    end

    assign char_ready   = ready_q;
    assign dit          = dit_q;
    assign dah          = dah_q;
    assign busy         = busy_q;
    assign char_invalid = inval_q;

endmodule
